alu_op_sequencer: RTL and testbench

Command sequencer in front of `ALU_TOP`. It accepts one ALU operation at a time over a valid/ready command port and drives `A`/`B`/`ALU_FUNC` into the ALU. It waits for the registered unit output, then selects the result of the unit addressed by the opcode and returns it over a valid/ready response port. It also traps divide-by-zero locally, checks the unit's valid flag, and counts completed operations.

---
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command/response bus between a requester and the ALU op sequencer.
// The requester drives commands and consumes responses (master); the
// sequencer accepts commands and presents responses (slave).
interface alu_op_sequencer_if #(
  parameter int Width = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_func;
  logic [Width-1:0] cmd_a;
  logic [Width-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [Width-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;
  logic [3:0]       rsp_func;

  modport master (
    output cmd_valid, cmd_func, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_func
  );

  modport slave (
    input  cmd_valid, cmd_func, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_func
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of ALU_TOP: accepts one operation at a time, drives the
// ALU operand/opcode registers, waits out the ALU latency, captures the result
// of the unit addressed by the opcode and returns it over a valid/ready port.
// Divide-by-zero is answered locally without touching the ALU.
module alu_op_sequencer #(
  parameter int Width   = 16,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  alu_op_sequencer_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [Width-1:0] alu_a,
  output logic [Width-1:0] alu_b,
  output logic [3:0]       alu_func,
  input  logic [Width-1:0] Arith_OUT,
  input  logic [Width-1:0] Logic_OUT,
  input  logic [Width-1:0] CMP_OUT,
  input  logic [Width-1:0] SHIFT_OUT,
  input  logic             Carry_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag
);

  localparam int CtrW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic [CtrW-1:0]  wait_cnt;
  logic             accept;
  logic             div_zero;
  logic             capture;
  logic             handshake;
  logic [Width-1:0] sel_data;
  logic             sel_carry;
  logic             sel_flag;

  // State register; reset drops any in-flight command.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus the accept/capture/handshake events it implies.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    div_zero   = (bus.cmd_func == 4'd3) && (bus.cmd_b == '0);
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          state_next = div_zero ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so no input-to-output paths.
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    busy          = (state != IDLE);
  end

  // Pick the unit addressed by the opcode's top two bits; carry only from Arith.
  always_comb begin
    sel_data  = Arith_OUT;
    sel_carry = 1'b0;
    sel_flag  = Arith_Flag;
    case (alu_func[3:2])
      2'b00: begin sel_data = Arith_OUT; sel_carry = Carry_OUT; sel_flag = Arith_Flag; end
      2'b01: begin sel_data = Logic_OUT; sel_flag = Logic_Flag; end
      2'b10: begin sel_data = CMP_OUT;   sel_flag = CMP_Flag;   end
      2'b11: begin sel_data = SHIFT_OUT; sel_flag = SHIFT_Flag; end
      default: begin sel_data = Arith_OUT; sel_flag = Arith_Flag; end
    endcase
  end

  // Datapath: ALU drive registers, latency counter, response fields, op counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_func      <= '0;
      wait_cnt      <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_func  <= '0;
      op_count      <= '0;
    end else begin
      if (accept) begin
        if (div_zero) begin
          bus.rsp_data  <= '0;
          bus.rsp_carry <= 1'b0;
          bus.rsp_err   <= 1'b1;
          bus.rsp_func  <= 4'd3;
        end else begin
          alu_a    <= bus.cmd_a;
          alu_b    <= bus.cmd_b;
          alu_func <= bus.cmd_func;
          wait_cnt <= CtrW'(ALU_LAT);
        end
      end
      if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CtrW'(1);
      end
      if (capture) begin
        bus.rsp_data  <= sel_data;
        bus.rsp_carry <= sel_carry;
        bus.rsp_err   <= ~sel_flag;
        bus.rsp_func  <= alu_func;
      end
      if (handshake) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU_TOP stand-in.
// The driver pushes expected responses on accept; a monitor pops and compares
// whenever a response is presented.
module tb_alu_op_sequencer;

  localparam int Width   = 16;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 2;
  localparam int CntMod  = 1 << CNT_W;

  typedef struct packed {
    logic [Width-1:0] data;
    logic             carry;
    logic             err;
    logic [3:0]       func;
    logic [31:0]      due;
  } exp_t;

  logic CLK_tb = 1'b0;
  logic RST    = 1'b1;
  always #5 CLK_tb = ~CLK_tb;

  alu_op_sequencer_if #(.Width(Width)) bus ();

  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [Width-1:0] alu_a, alu_b;
  logic [3:0]       alu_func;

  logic [Width-1:0] arith_q, logic_q, cmp_q, shift_q;
  logic             carry_q;
  logic [3:0]       flag_q;
  logic             logic_flag_w;
  logic [Width:0]   ar_c, lo_c, cm_c, sh_c;

  int   cyc = 0;
  int   kill_at = -1;
  bit   rand_ready = 1'b0;
  logic rdy_dir = 1'b1;
  logic rdy_rand = 1'b1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cnt_model = 0;
  exp_t exp_q[$];
  logic [Width-1:0] mdl_a, mdl_b;
  logic [3:0]       mdl_func;

  assign bus.rsp_ready = rand_ready ? rdy_rand : rdy_dir;

  alu_op_sequencer #(.Width(Width), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .CLK        (CLK_tb),
    .RST        (RST),
    .bus        (bus),
    .busy       (busy),
    .op_count   (op_count),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .Arith_OUT  (arith_q),
    .Logic_OUT  (logic_q),
    .CMP_OUT    (cmp_q),
    .SHIFT_OUT  (shift_q),
    .Carry_OUT  (carry_q),
    .Arith_Flag (flag_q[0]),
    .Logic_Flag (logic_flag_w),
    .CMP_Flag   (flag_q[2]),
    .SHIFT_Flag (flag_q[3])
  );

  // ALU_TOP opcode semantics: returns {carry, result}.
  function automatic logic [Width:0] unit_calc(input logic [3:0] f,
                                               input logic [Width-1:0] a,
                                               input logic [Width-1:0] b);
    logic [Width:0] r;
    r = '0;
    case (f)
      4'd0:  r = {1'b0, a} + {1'b0, b};
      4'd1:  r = {(a < b), a - b};
      4'd2:  r = {1'b0, a * b};
      4'd3:  r = (b == '0) ? '0 : {1'b0, a / b};
      4'd4:  r = {1'b0, a & b};
      4'd5:  r = {1'b0, a | b};
      4'd6:  r = {1'b0, ~(a & b)};
      4'd7:  r = {1'b0, ~(a | b)};
      4'd8:  r = '0;
      4'd9:  r = (a == b) ? (Width+1)'(1) : '0;
      4'd10: r = (a > b)  ? (Width+1)'(2) : '0;
      4'd11: r = (a < b)  ? (Width+1)'(3) : '0;
      4'd12: r = {1'b0, a >> 1};
      4'd13: r = {1'b0, a << 1};
      4'd14: r = {1'b0, b >> 1};
      default: r = {1'b0, b << 1};
    endcase
    return r;
  endfunction

  // Expected response of one command, straight from the sequencer's rules.
  function automatic exp_t ref_rsp(input logic [3:0] f, input logic [Width-1:0] a,
                                   input logic [Width-1:0] b, input bit force_err,
                                   input int due);
    exp_t e;
    logic [Width:0] r;
    e.due = 32'(due);
    if (f == 4'd3 && b == '0) begin
      e.data = '0; e.carry = 1'b0; e.err = 1'b1; e.func = 4'd3;
    end else begin
      r = unit_calc(f, a, b);
      e.data  = r[Width-1:0];
      e.carry = (f < 4'd4) ? r[Width] : 1'b0;
      e.err   = force_err;
      e.func  = f;
    end
    return e;
  endfunction

  // ALU stand-in: every unit computes from the current opcode's low bits,
  // so a wrong unit select shows up as wrong data; only the addressed unit
  // raises its flag.
  always_comb begin
    ar_c = unit_calc({2'b00, alu_func[1:0]}, alu_a, alu_b);
    lo_c = unit_calc({2'b01, alu_func[1:0]}, alu_a, alu_b);
    cm_c = unit_calc({2'b10, alu_func[1:0]}, alu_a, alu_b);
    sh_c = unit_calc({2'b11, alu_func[1:0]}, alu_a, alu_b);
  end

  always @(posedge CLK_tb) begin
    arith_q <= ar_c[Width-1:0];
    carry_q <= ar_c[Width];
    logic_q <= lo_c[Width-1:0];
    cmp_q   <= cm_c[Width-1:0];
    shift_q <= sh_c[Width-1:0];
    flag_q  <= 4'b0001 << alu_func[3:2];
    cyc     <= cyc + 1;
  end

  assign logic_flag_w = flag_q[1] && (cyc != kill_at);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired (cyc %0d)", name, cyc);
  endtask

  // Issue one command; returns just after the accept edge (posedge + #1).
  task automatic apply_stimulus(input logic [3:0] f, input logic [Width-1:0] a,
                                input logic [Width-1:0] b, input bit force_err);
    bit ok;
    bit dz;
    ok = 1'b0;
    dz = (f == 4'd3) && (b == '0);
    bus.cmd_valid = 1'b1;
    bus.cmd_func  = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK_tb);
      if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge CLK_tb);
    #1;
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      report_fail("accept_timeout");
    end else begin
      exp_q.push_back(ref_rsp(f, a, b, force_err, cyc + (dz ? 0 : ALU_LAT + 1)));
      if (!dz) begin mdl_a = a; mdl_b = b; mdl_func = f; end
      check_output("alu_a", 32'(alu_a), 32'(mdl_a));
      check_output("alu_b", 32'(alu_b), 32'(mdl_b));
      check_output("alu_func", 32'(alu_func), 32'(mdl_func));
    end
  endtask

  // Wait until every expected response has been consumed, then optionally
  // check that the sequencer is back to accepting on the following cycle.
  task automatic wait_idle(input bit chk);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_tb);
      #2;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    @(posedge CLK_tb);
    #1;
    if (!ok) report_fail("drain_timeout");
    else if (chk) begin
      check_output("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("idle_busy", 32'(busy), 32'd0);
      check_output("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_op_count", 32'(op_count), 32'd0);
    check_output("rst_alu_a", 32'(alu_a), 32'd0);
    check_output("rst_alu_b", 32'(alu_b), 32'd0);
    check_output("rst_alu_func", 32'(alu_func), 32'd0);
    check_output("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_output("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    check_output("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_output("rst_rsp_func", 32'(bus.rsp_func), 32'd0);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    exp_t e;
    bit   prev_valid;
    bit   chk_cnt;
    prev_valid = 1'b0;
    chk_cnt    = 1'b0;
    forever begin
      @(negedge CLK_tb);
      if (RST) begin
        exp_q.delete();
        cnt_model  = 0;
        chk_cnt    = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (chk_cnt) begin
          check_output("op_count", 32'(op_count), 32'(cnt_model));
          chk_cnt = 1'b0;
        end
        if (bus.rsp_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_rsp: rsp_valid high, no response pending (cyc %0d)", cyc);
          end else begin
            e = exp_q[0];
            if (!prev_valid) check_output("rsp_latency_cyc", 32'(cyc), e.due);
            check_output("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check_output("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
            check_output("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check_output("rsp_func", 32'(bus.rsp_func), 32'(e.func));
            check_output("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_output("resp_busy", 32'(busy), 32'd1);
            if (bus.rsp_ready === 1'b1) begin
              void'(exp_q.pop_front());
              cnt_model = (cnt_model + 1) % CntMod;
              chk_cnt   = 1'b1;
            end
          end
        end
        prev_valid = (bus.rsp_valid === 1'b1);
      end
    end
  end

  // Random response backpressure, active only during the random phase.
  initial begin
    forever begin
      @(posedge CLK_tb);
      #1;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    report_fail("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    logic [3:0]       f;
    logic [Width-1:0] a, b;
    bus.cmd_valid = 1'b0;
    bus.cmd_func  = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    mdl_a = '0; mdl_b = '0; mdl_func = '0;
    RST = 1'b1;
    repeat (2) @(posedge CLK_tb);
    #1;
    check_reset_outputs();
    RST = 1'b0;
    $display("[TB] reset released");

    // Add, divide-by-zero, divide, and one op from each other unit.
    apply_stimulus(4'd0, 16'd10, 16'd20, 1'b0);  wait_idle(1'b1);
    apply_stimulus(4'd3, 16'd20, 16'd0, 1'b0);   wait_idle(1'b1);
    apply_stimulus(4'd3, 16'd20, 16'd10, 1'b0);  wait_idle(1'b1);
    apply_stimulus(4'd7, 16'd20, 16'd10, 1'b0);  wait_idle(1'b1);
    apply_stimulus(4'd10, 16'd20, 16'd10, 1'b0); wait_idle(1'b1);
    apply_stimulus(4'd13, 16'd20, 16'd0, 1'b0);  wait_idle(1'b1);
    apply_stimulus(4'd0, 16'hFFFF, 16'd2, 1'b0); wait_idle(1'b1);

    // Backpressure: response must hold while rsp_ready is low.
    rdy_dir = 1'b0;
    apply_stimulus(4'd5, 16'h00F0, 16'h0F00, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(negedge CLK_tb);
        if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
      end
      if (!seen) report_fail("bp_rsp_timeout");
    end
    repeat (5) @(negedge CLK_tb);
    #1;
    check_output("bp_op_count_held", 32'(op_count), 32'(cnt_model));
    @(posedge CLK_tb);
    #1;
    rdy_dir = 1'b1;
    wait_idle(1'b1);

    // Logic flag low at the capture sample -> error; low one cycle earlier -> ignored.
    kill_at = cyc + 2;
    apply_stimulus(4'd4, 16'h0F0F, 16'h00FF, 1'b1); wait_idle(1'b1);
    kill_at = cyc + 1;
    apply_stimulus(4'd4, 16'h1234, 16'hFF00, 1'b0); wait_idle(1'b1);
    kill_at = -1;

    // Reset while waiting on the ALU: no response, everything back to zero.
    apply_stimulus(4'd1, 16'd100, 16'd200, 1'b0);
    RST = 1'b1;
    @(posedge CLK_tb);
    #1;
    mdl_a = '0; mdl_b = '0; mdl_func = '0;
    check_reset_outputs();
    RST = 1'b0;
    repeat (6) @(posedge CLK_tb);
    #1;
    check_output("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      f = 4'($urandom_range(0, 15));
      a = Width'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : Width'($urandom);
      apply_stimulus(f, a, b, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK_tb);
        #1;
      end
    end
    rdy_dir = 1'b1;
    rand_ready = 1'b0;
    wait_idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
